// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, 4-bit op encodings and op helpers.
package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_CMP = 4'd2,
        ALU_MOV = 4'd3,
        ALU_MUL = 4'd4,
        ALU_DIV = 4'd5,
        ALU_MOD = 4'd6,
        ALU_ORR = 4'd7,
        ALU_AND = 4'd8,
        ALU_SLT = 4'd9,
        ALU_SLE = 4'd10,
        ALU_SGT = 4'd11,
        ALU_SGE = 4'd12,
        ALU_SEQ = 4'd13,
        ALU_SNE = 4'd14,
        ALU_LSL = 4'd15
    } alu_op_t;

    // CMP only updates flags, so it never claims its destination register.
    function automatic logic op_writes_rd(input alu_op_t op);
        return op != ALU_CMP;
    endfunction

endpackage

// File: rtl/op_regfile.sv
// Register file, 2 async read ports / 1 write port; OPSTAGE_BYPASS_EN forwards the write data to matching reads.
// Reads are combinational; write lands on the rising edge; no backpressure.
module op_regfile #(
    parameter int  DATA_W = alu_pkg::DATA_W,
    parameter int  NREGS  = 16,
    localparam int IDX_W  = $clog2(NREGS)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [IDX_W-1:0]  rd_a_idx_i,
    output logic [DATA_W-1:0] rd_a_dat_o,
    input  logic [IDX_W-1:0]  rd_b_idx_i,
    output logic [DATA_W-1:0] rd_b_dat_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_dat_i
);

    logic [DATA_W-1:0] regs_q [NREGS];

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            regs_q[wr_idx_i] <= wr_dat_i;
        end
    end

`ifdef OPSTAGE_BYPASS_EN
    logic hit_a, hit_b;

    assign hit_a      = wr_en_i && (wr_idx_i == rd_a_idx_i);
    assign hit_b      = wr_en_i && (wr_idx_i == rd_b_idx_i);
    assign rd_a_dat_o = hit_a ? wr_dat_i : regs_q[rd_a_idx_i];
    assign rd_b_dat_o = hit_b ? wr_dat_i : regs_q[rd_b_idx_i];
`else
    assign rd_a_dat_o = regs_q[rd_a_idx_i];
    assign rd_b_dat_o = regs_q[rd_b_idx_i];
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage: regfile read, busy-bit scoreboard and ALU output register; OPSTAGE_BYPASS_EN enables writeback forwarding.
// 1-cycle latency from acceptance; dec_ready drops on a source hazard or while a held output is not consumed.
module alu_operand_stage #(
    parameter int  DATA_W = alu_pkg::DATA_W,
    parameter int  NREGS  = 16,
    localparam int IDX_W  = $clog2(NREGS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     dec_valid,
    output logic                     dec_ready,
    input  logic [3:0]               dec_op,
    input  logic [IDX_W-1:0]         dec_rd,
    input  logic [IDX_W-1:0]         dec_rn,
    input  logic [IDX_W-1:0]         dec_rm,
    input  logic                     dec_imm_sel,
    input  logic [DATA_W-1:0]        dec_imm,
    input  logic                     wb_en,
    input  logic [IDX_W-1:0]         wb_rd,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     alu_valid,
    input  logic                     alu_ready,
    output logic signed [DATA_W-1:0] alu_in1,
    output logic signed [DATA_W-1:0] alu_in2,
    output logic [3:0]               alu_ctrl,
    output logic [IDX_W-1:0]         alu_rd,
    output logic                     alu_wr
);

    import alu_pkg::*;

    logic [NREGS-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] rn_dat, rm_dat;
    logic              wb_hit_rn, wb_hit_rm;
    logic              rn_haz, rm_haz, hazard;
    logic              out_free, accept, dec_wr;

    logic              alu_valid_q, alu_valid_d;
    logic [DATA_W-1:0] alu_in1_q, alu_in1_d;
    logic [DATA_W-1:0] alu_in2_q, alu_in2_d;
    logic [3:0]        alu_ctrl_q, alu_ctrl_d;
    logic [IDX_W-1:0]  alu_rd_q, alu_rd_d;
    logic              alu_wr_q, alu_wr_d;

    op_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clock_i    (clock),
        .reset_i    (reset),
        .rd_a_idx_i (dec_rn),
        .rd_a_dat_o (rn_dat),
        .rd_b_idx_i (dec_rm),
        .rd_b_dat_o (rm_dat),
        .wr_en_i    (wb_en),
        .wr_idx_i   (wb_rd),
        .wr_dat_i   (wb_data)
    );

    assign wb_hit_rn = wb_en && (wb_rd == dec_rn);
    assign wb_hit_rm = wb_en && (wb_rd == dec_rm);

`ifdef OPSTAGE_BYPASS_EN
    // The writeback value is forwarded, so a pending result arriving now resolves the hazard.
    assign rn_haz = busy_q[dec_rn] && !wb_hit_rn;
    assign rm_haz = busy_q[dec_rm] && !wb_hit_rm;
`else
    // Without forwarding the regfile still holds the old value this cycle; wait for the write to land.
    assign rn_haz = busy_q[dec_rn] || wb_hit_rn;
    assign rm_haz = busy_q[dec_rm] || wb_hit_rm;
`endif

    assign hazard    = rn_haz || (rm_haz && !dec_imm_sel);
    assign out_free  = !alu_valid_q || alu_ready;
    assign dec_ready = out_free && !hazard;
    assign accept    = dec_valid && dec_ready;
    assign dec_wr    = op_writes_rd(alu_op_t'(dec_op));

    // Clear first so a same-cycle claim of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (accept && dec_wr) begin
            busy_d[dec_rd] = 1'b1;
        end
    end

    always_comb begin
        alu_valid_d = alu_valid_q;
        alu_in1_d   = alu_in1_q;
        alu_in2_d   = alu_in2_q;
        alu_ctrl_d  = alu_ctrl_q;
        alu_rd_d    = alu_rd_q;
        alu_wr_d    = alu_wr_q;
        if (accept) begin
            alu_valid_d = 1'b1;
            alu_in1_d   = rn_dat;
            alu_in2_d   = dec_imm_sel ? dec_imm : rm_dat;
            alu_ctrl_d  = dec_op;
            alu_rd_d    = dec_rd;
            alu_wr_d    = dec_wr;
        end else if (alu_ready) begin
            alu_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q      <= '0;
            alu_valid_q <= 1'b0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_ctrl_q  <= '0;
            alu_rd_q    <= '0;
            alu_wr_q    <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            alu_valid_q <= alu_valid_d;
            alu_in1_q   <= alu_in1_d;
            alu_in2_q   <= alu_in2_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_rd_q    <= alu_rd_d;
            alu_wr_q    <= alu_wr_d;
        end
    end

    assign alu_valid = alu_valid_q;
    assign alu_in1   = $signed(alu_in1_q);
    assign alu_in2   = $signed(alu_in2_q);
    assign alu_ctrl  = alu_ctrl_q;
    assign alu_rd    = alu_rd_q;
    assign alu_wr    = alu_wr_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: expected operands queued at acceptance, compared while alu_valid is high.
module tb_alu_operand_stage;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  ctrl;
        logic [3:0]  rd;
        logic        wr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dec_valid = 1'b0;
    logic        dec_ready;
    logic [3:0]  dec_op = '0;
    logic [3:0]  dec_rd = '0;
    logic [3:0]  dec_rn = '0;
    logic [3:0]  dec_rm = '0;
    logic        dec_imm_sel = 1'b0;
    logic [31:0] dec_imm = '0;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        alu_valid;
    logic        alu_ready = 1'b1;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_ctrl;
    logic [3:0]  alu_rd;
    logic        alu_wr;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb[$];
    logic [31:0] model [16];

    alu_operand_stage #(.DATA_W(32), .NREGS(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_op      (dec_op),
        .dec_rd      (dec_rd),
        .dec_rn      (dec_rn),
        .dec_rm      (dec_rm),
        .dec_imm_sel (dec_imm_sel),
        .dec_imm     (dec_imm),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_ctrl    (alu_ctrl),
        .alu_rd      (alu_rd),
        .alu_wr      (alu_wr)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Reference register contents, tracking only the writeback port.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) model[i] <= '0;
        end else if (wb_en) begin
            model[wb_rd] <= wb_data;
        end
    end

    // Compare the presented operands against the oldest accepted instruction, then record new acceptances.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            sb.delete();
        end else begin
            if (alu_valid) begin
                if (sb.size() == 0) begin
                    check("sb_spurious_valid", 64'(alu_valid), 64'h0);
                end else begin
                    e = sb[0];
                    check("sb_in1", 64'(alu_in1), 64'(e.in1));
                    check("sb_in2", 64'(alu_in2), 64'(e.in2));
                    check("sb_ctrl", 64'(alu_ctrl), 64'(e.ctrl));
                    check("sb_rd", 64'(alu_rd), 64'(e.rd));
                    check("sb_wr", 64'(alu_wr), 64'(e.wr));
                    if (alu_ready) void'(sb.pop_front());
                end
            end
            if (dec_valid && dec_ready) begin
`ifdef OPSTAGE_BYPASS_EN
                e.in1 = (wb_en && wb_rd == dec_rn) ? wb_data : model[dec_rn];
                e.in2 = dec_imm_sel ? dec_imm : ((wb_en && wb_rd == dec_rm) ? wb_data : model[dec_rm]);
`else
                e.in1 = model[dec_rn];
                e.in2 = dec_imm_sel ? dec_imm : model[dec_rm];
`endif
                e.ctrl = dec_op;
                e.rd   = dec_rd;
                e.wr   = (dec_op != 4'd2);
                sb.push_back(e);
            end
        end
    end

    task automatic sync;
        @(posedge clock);
        #1;
    endtask

    task automatic do_wb(input logic [3:0] idx, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_rd   = idx;
        wb_data = data;
        sync();
        wb_en   = 1'b0;
    endtask

    task automatic drive_dec(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rn,
                             input logic [3:0] rm, input logic sel, input logic [31:0] imm);
        dec_op      = op;
        dec_rd      = rd;
        dec_rn      = rn;
        dec_rm      = rm;
        dec_imm_sel = sel;
        dec_imm     = imm;
        dec_valid   = 1'b1;
    endtask

    task automatic wait_accept(input string tag, input int max_wait, output int waits);
        waits = 0;
        forever begin
            @(negedge clock);
            if (dec_ready) break;
            waits++;
            if (waits >= max_wait) begin
                check({tag, "_timeout"}, 64'(dec_ready), 64'h1);
                break;
            end
            sync();
        end
        sync();
        dec_valid = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, got hang, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_dec_ready", 64'(dec_ready), 64'h1);
        check("rst_alu_valid", 64'(alu_valid), 64'h0);
        check("rst_alu_in1", 64'(alu_in1), 64'h0);
        check("rst_alu_wr", 64'(alu_wr), 64'h0);
        sync();
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", 64'(dec_ready), 64'h1);
        sync();

        // Basic issue with immediate operand.
        do_wb(4'd3, 32'd5);
        drive_dec(ALU_ADD, 4'd1, 4'd3, 4'd0, 1'b1, 32'd7);
        wait_accept("s35", 20, w);
        check("s35_wait", 64'(w), 64'h0);
        @(negedge clock);
        check("s35_valid", 64'(alu_valid), 64'h1);
        check("s35_in1", 64'(alu_in1), 64'd5);
        check("s35_in2", 64'(alu_in2), 64'd7);
        check("s35_ctrl", 64'(alu_ctrl), 64'd0);
        check("s35_rd", 64'(alu_rd), 64'd1);
        check("s35_wr", 64'(alu_wr), 64'd1);
        sync();
        do_wb(4'd1, 32'hDEAD_0001);

        // RAW hazard resolved by writeback.
        drive_dec(ALU_SUB, 4'd2, 4'd0, 4'd0, 1'b0, 32'd0);
        wait_accept("s36a", 20, w);
        check("s36a_wait", 64'(w), 64'h0);
        drive_dec(ALU_ADD, 4'd4, 4'd2, 4'd2, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("s36_stall", 64'(dec_ready), 64'h0);
            sync();
        end
        wb_en   = 1'b1;
        wb_rd   = 4'd2;
        wb_data = 32'h1234_5678;
        @(negedge clock);
`ifdef OPSTAGE_BYPASS_EN
        check("s36_wb_cycle_ready", 64'(dec_ready), 64'h1);
        sync();
        wb_en     = 1'b0;
        dec_valid = 1'b0;
`else
        check("s36_wb_cycle_ready", 64'(dec_ready), 64'h0);
        sync();
        wb_en = 1'b0;
        @(negedge clock);
        check("s36_next_ready", 64'(dec_ready), 64'h1);
        sync();
        dec_valid = 1'b0;
`endif
        @(negedge clock);
        check("s36_in1", 64'(alu_in1), 64'h1234_5678);
        check("s36_in2", 64'(alu_in2), 64'h1234_5678);
        sync();
        do_wb(4'd4, 32'h44);

        // Output backpressure for three cycles with a pending instruction.
        do_wb(4'd7, 32'hF0);
        do_wb(4'd8, 32'h0F);
        alu_ready = 1'b0;
        drive_dec(ALU_ORR, 4'd6, 4'd7, 4'd8, 1'b0, 32'd0);
        wait_accept("s37a", 20, w);
        check("s37a_wait", 64'(w), 64'h0);
        drive_dec(ALU_AND, 4'd9, 4'd7, 4'd0, 1'b1, 32'hFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("s37_ready", 64'(dec_ready), 64'h0);
            check("s37_hold_in1", 64'(alu_in1), 64'hF0);
            check("s37_hold_in2", 64'(alu_in2), 64'h0F);
            check("s37_hold_ctrl", 64'(alu_ctrl), 64'd7);
            sync();
        end
        alu_ready = 1'b1;
        @(negedge clock);
        check("s37_release_ready", 64'(dec_ready), 64'h1);
        sync();
        dec_valid = 1'b0;
        @(negedge clock);
        check("s37_b_in2", 64'(alu_in2), 64'hFF);
        check("s37_b_ctrl", 64'(alu_ctrl), 64'd8);
        sync();

        // CMP leaves its destination free.
        drive_dec(ALU_CMP, 4'd13, 4'd7, 4'd8, 1'b0, 32'd0);
        wait_accept("s38a", 20, w);
        @(negedge clock);
        check("s38_cmp_wr", 64'(alu_wr), 64'h0);
        sync();
        drive_dec(ALU_ADD, 4'd14, 4'd13, 4'd0, 1'b1, 32'd1);
        wait_accept("s38b", 20, w);
        check("s38_no_stall", 64'(w), 64'h0);

        // Back-to-back acceptances keep alu_valid high.
        drive_dec(ALU_ADD, 4'd10, 4'd7, 4'd0, 1'b1, 32'd1);
        @(negedge clock);
        check("b2b_first_ready", 64'(dec_ready), 64'h1);
        sync();
        drive_dec(ALU_SUB, 4'd11, 4'd8, 4'd0, 1'b1, 32'd2);
        @(negedge clock);
        check("b2b_valid_a", 64'(alu_valid), 64'h1);
        check("b2b_second_ready", 64'(dec_ready), 64'h1);
        sync();
        dec_valid = 1'b0;
        @(negedge clock);
        check("b2b_valid_b", 64'(alu_valid), 64'h1);
        check("b2b_in1_b", 64'(alu_in1), 64'h0F);
        sync();
        @(negedge clock);
        check("b2b_drained", 64'(alu_valid), 64'h0);
        sync();

        // Same-cycle claim and writeback of r5: the claim must stick.
        drive_dec(ALU_MUL, 4'd5, 4'd7, 4'd8, 1'b0, 32'd0);
        wb_en   = 1'b1;
        wb_rd   = 4'd5;
        wb_data = 32'h55;
        wait_accept("s39a", 20, w);
        wb_en = 1'b0;
        check("s39a_wait", 64'(w), 64'h0);
        drive_dec(ALU_SEQ, 4'd15, 4'd5, 4'd0, 1'b1, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("s39_busy_r5", 64'(dec_ready), 64'h0);
            sync();
        end
        dec_valid = 1'b0;

        // Reset while an output is held and an instruction is stalled.
        alu_ready = 1'b0;
        drive_dec(ALU_ORR, 4'd12, 4'd7, 4'd8, 1'b0, 32'd0);
        wait_accept("s40a", 20, w);
        drive_dec(ALU_SEQ, 4'd15, 4'd5, 4'd0, 1'b1, 32'd0);
        @(negedge clock);
        check("s40_pre_valid", 64'(alu_valid), 64'h1);
        check("s40_pre_ready", 64'(dec_ready), 64'h0);
        sync();
        #2;
        reset = 1'b1;
        #1;
        check("s40_rst_valid", 64'(alu_valid), 64'h0);
        check("s40_rst_ready", 64'(dec_ready), 64'h1);
        check("s40_rst_in1", 64'(alu_in1), 64'h0);
        check("s40_rst_ctrl", 64'(alu_ctrl), 64'h0);
        dec_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset     = 1'b0;
        alu_ready = 1'b1;
        @(negedge clock);
        check("s40_post_valid", 64'(alu_valid), 64'h0);
        check("s40_post_ready", 64'(dec_ready), 64'h1);
        sync();
        drive_dec(ALU_ADD, 4'd1, 4'd3, 4'd5, 1'b0, 32'd0);
        wait_accept("s40b", 20, w);
        check("s40_busy_cleared", 64'(w), 64'h0);
        @(negedge clock);
        check("s40_r3_zero", 64'(alu_in1), 64'h0);
        check("s40_r5_zero", 64'(alu_in2), 64'h0);
        sync();

        repeat (3) sync();
        check("sb_drain", 64'(sb.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and register width.
REQ-002 The block SHALL have parameter NREGS, default 16, giving the register count; index width is log2(NREGS).
REQ-003 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port dec_valid, input, 1 bit: decoded instruction present.
REQ-006 The block SHALL have port dec_ready, output, 1 bit: stage accepts the instruction this cycle.
REQ-007 The block SHALL have port dec_op, input, 4 bits: ALU control code.
REQ-008 The block SHALL have ports dec_rd, dec_rn and dec_rm, input, 4 bits each: destination and source indices.
REQ-009 The block SHALL have ports dec_imm_sel (input, 1 bit) and dec_imm (input, 32 bits): immediate replaces the rm operand.
REQ-010 The block SHALL have ports wb_en (input, 1 bit), wb_rd (input, 4 bits) and wb_data (input, 32 bits): writeback port.
REQ-011 The block SHALL have port alu_valid, output, 1 bit: operands valid toward the ALU.
REQ-012 The block SHALL have port alu_ready, input, 1 bit: ALU consumes the operands.
REQ-013 The block SHALL have ports alu_in1 and alu_in2, output, 32 bits each, signed: ALU operands.
REQ-014 The block SHALL have port alu_ctrl, output, 4 bits: ALU control code.
REQ-015 The block SHALL have ports alu_rd (output, 4 bits) and alu_wr (output, 1 bit): destination index and result-writes flag.

Function
REQ-016 The stage SHALL hold an NREGS x DATA_W register file, written at the clock edge when wb_en=1; no register is hardwired.
REQ-017 dec_ready SHALL equal (!alu_valid | alu_ready) & !hazard, where hazard means rn is busy, or rm is busy with dec_imm_sel=0.
REQ-018 The stage SHALL load the output register on dec_valid & dec_ready, giving 1-cycle latency from acceptance to alu_valid=1.
REQ-019 alu_in1 SHALL be read from rn; alu_in2 SHALL be dec_imm when dec_imm_sel=1, else read from rm.
REQ-020 alu_wr SHALL be 0 for op 2 (compare, flags only) and 1 for all other ops.
REQ-021 alu_valid SHALL clear on alu_ready with no new acceptance, and SHALL remain 1 across back-to-back acceptances.
REQ-022 While alu_valid=1 and alu_ready=0, all alu_* outputs SHALL hold stable.
REQ-023 The scoreboard SHALL keep one busy bit per register: accepting an instruction with alu_wr=1 sets busy[rd], and wb_en clears busy[wb_rd].
REQ-024 When a set and a clear of the same busy bit occur in the same cycle, the set SHALL win.
REQ-025 When rn equals rm, the hazard check SHALL consider that single register once.
REQ-026 dec_valid=0 SHALL never change busy bits or the register file, except through the writeback port.

Reset
REQ-027 Reset SHALL asynchronously clear all registers to 0, all busy bits, alu_valid, alu_in1, alu_in2, alu_ctrl, alu_rd and alu_wr.
REQ-028 dec_ready SHALL read 1 during and immediately after reset.
REQ-029 An instruction in flight when reset asserts SHALL be discarded.

Configuration
REQ-030 With OPSTAGE_BYPASS_EN defined, a source matching wb_rd while wb_en=1 SHALL read wb_data and SHALL NOT count as a hazard in that cycle.
REQ-031 Without OPSTAGE_BYPASS_EN, that case SHALL be a hazard (stall one cycle), and the instruction SHALL read the register file value on the following cycle.

Structure
REQ-032 Package alu_pkg SHALL hold DATA_W, the 4-bit op encodings, and an alu_op_t typedef.
REQ-033 Op encodings: ADD=0, SUB=1, CMP=2, MOV=3, MUL=4, DIV=5, MOD=6, ORR=7, AND=8, SLT=9, SLE=10, SGT=11, SGE=12, SEQ=13, SNE=14, LSL=15.
REQ-034 The register file with its read-bypass SHALL be a sub-module named op_regfile: two read ports, one write port.

Verification
REQ-035 Scenario: after reset, write r3=5 via wb, then issue ADD r1,r3,imm 7 -> next cycle alu_valid=1, alu_in1=5, alu_in2=7, alu_ctrl=0, alu_rd=1, alu_wr=1.
REQ-036 Scenario: issue SUB r2,... then ADD r4,r2,r2 -> dec_ready=0 until wb r2; with bypass, acceptance is the same cycle as wb and alu_in1 = wb_data; without bypass, acceptance is one cycle later.
REQ-037 Scenario: alu_ready=0 for 3 cycles with a new dec_valid pending -> alu_* outputs held stable, dec_ready=0, no operand lost or duplicated.
REQ-038 Scenario: CMP r1,r2 accepted -> alu_wr=0, busy[r1] unchanged, and a dependent read of r1 is not stalled.
REQ-039 Scenario: same-cycle acceptance of dest r5 and wb_en to r5 -> busy[r5]=1 afterwards.
REQ-040 Scenario: reset asserted mid-stall -> alu_valid=0, all busy bits cleared, and reads of r3 return 0.
